// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the MMIO UART: register offsets, STATUS bit positions,
// shifter state encoding and the 100 MHz / 115200 baud divisor.
package uart_tx_mmio_pkg;
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int DIV_RESET_115K = 867;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [3:0] sat_cnt4(input logic [31:0] c);
    return (c > 32'd15) ? 4'd15 : c[3:0];
  endfunction
endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter. A push while full is
// accepted when a pop frees the slot in the same cycle.
module uart_tx_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, a baud-timed
// shifter drains it onto a registered serial line.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h1010,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_RESET  = DIV_RESET_115K,
  parameter logic [2:0]  MEM_STATE  = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        en,
  input  logic        load_enable,
  input  logic        store_enable,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_rxd_out,
  output logic        tx_idle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel, wr, push_req, pop, full, empty, bit_end;
  logic [1:0]    offset;
  logic [7:0]    rdata, shreg;
  logic [CW-1:0] count;
  logic [15:0]   divisor, bit_div, cnt;
  logic [2:0]    idx;
  logic          overflow;
  logic [31:0]   status;
  tx_state_e     st, st_nx;

  // Loads are width-agnostic and only sw/sb matter for DIVISOR writes.
  logic unused;
  assign unused = ^{load_enable, is_sh, is_sw, address[1:0], data_in[31:16]};

  assign sel      = en && (address[31:4] == BASE[31:4]);
  assign offset   = address[3:2];
  assign wr       = sel && store_enable && (state == MEM_STATE);
  assign push_req = wr && (offset == OFF_TXDATA);

  uart_tx_mmio_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (data_in[7:0]),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    st_nx   = st;
    pop     = 1'b0;
    bit_end = (cnt == bit_div);
    case (st)
      TX_IDLE:  if (!empty) begin pop = 1'b1; st_nx = TX_START; end
      TX_START: if (bit_end) st_nx = TX_DATA;
      TX_DATA:  if (bit_end && idx == 3'd7) st_nx = TX_STOP;
      TX_STOP:
        if (bit_end) begin
          if (!empty) begin pop = 1'b1; st_nx = TX_START; end
          else st_nx = TX_IDLE;
        end
      default:  st_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= TX_IDLE;
      uart_rxd_out <= 1'b1;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      bit_div      <= '0;
    end else begin
      st <= st_nx;
      // Line follows the current state, so it lags the state register by one clock.
      case (st)
        TX_START: uart_rxd_out <= 1'b0;
        TX_DATA:  uart_rxd_out <= shreg[0];
        default:  uart_rxd_out <= 1'b1;
      endcase
      if (pop) begin
        shreg   <= rdata;
        bit_div <= divisor;
        cnt     <= '0;
        idx     <= '0;
      end else if (st != TX_IDLE) begin
        if (bit_end) begin
          cnt <= '0;
          if (st == TX_DATA) begin
            idx   <= idx + 3'd1;
            shreg <= shreg >> 1;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= 16'(DIV_RESET);
      overflow <= 1'b0;
    end else begin
      if (wr && offset == OFF_DIVISOR) begin
        if (is_sb) divisor[7:0] <= data_in[7:0];
        else       divisor      <= data_in[15:0];
      end
      if (wr && offset == OFF_STATUS)        overflow <= 1'b0;
      else if (push_req && full && !pop)     overflow <= 1'b1;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_FULL]                = full;
    status[ST_EMPTY]               = empty;
    status[ST_BUSY]                = (st != TX_IDLE);
    status[ST_OVF]                 = overflow;
    status[ST_CNT_LSB+3:ST_CNT_LSB] = sat_cnt4(32'(count));
    data_out = '0;
    if (sel) begin
      case (offset)
        OFF_STATUS:  data_out = status;
        OFF_DIVISOR: data_out = {16'd0, divisor};
        default:     data_out = '0;
      endcase
    end
  end

  assign tx_idle = empty && (st == TX_IDLE);
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line-level receiver model pops expected
// bytes and bit periods from a scoreboard queue filled as TXDATA stores are issued.
module tb_uart_tx_mmio;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  state = '0;
  logic        en = 0, load_enable = 0, store_enable = 0, is_sb = 0, is_sh = 0, is_sw = 0;
  logic [31:0] address = '0, data_in = '0, data_out;
  logic        uart_rxd_out, tx_idle;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .state(state), .en(en), .load_enable(load_enable),
    .store_enable(store_enable), .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
    .address(address), .data_in(data_in), .data_out(data_out),
    .uart_rxd_out(uart_rxd_out), .tx_idle(tx_idle)
  );

  localparam logic [31:0] A_TX = 32'h1010, A_ST = 32'h1014, A_DIV = 32'h1018, A_RSV = 32'h101C;

  int checks = 0, errors = 0;
  typedef struct {logic [7:0] b; int per;} exp_t;
  exp_t sbq[$];
  int   fstart[$];
  bit   rx_en = 1, rx_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit sb);
    @(negedge clk);
    en = 1; store_enable = 1; state = 3'd3; address = a; data_in = d; is_sb = sb; is_sw = !sb;
    @(negedge clk);
    en = 0; store_enable = 0; state = 3'd0; is_sb = 0; is_sw = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    en = 1; load_enable = 1; address = a;
    #1 d = data_out;
    en = 0; load_enable = 0;
  endtask

  task automatic tx(input logic [7:0] b, input int per, input bit sb);
    exp_t e;
    e.b = b; e.per = per;
    sbq.push_back(e);
    st(A_TX, {24'h5A5A5A, b}, sb);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || rx_busy) && n < budget) begin
      @(negedge clk); n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Receiver model: exact per-bit duration and level checks, centre-sampled byte.
  initial begin : rxm
    logic prev, expb;
    logic [7:0] got;
    exp_t e;
    bit ok, abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_en && prev && uart_rxd_out === 1'b0) begin
        rx_busy = 1; abort = 0; got = '0;
        fstart.push_back(cyc);
        if (sbq.size() == 0) begin
          check("unexpected_frame", 32'(sbq.size()), 32'd1);
          e.b = 8'h00; e.per = 1;
        end else e = sbq.pop_front();
        for (int k = 0; k < 10; k++) begin
          expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e.b[k-1];
          ok = 1;
          for (int j = 0; j < e.per; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (!rx_en) abort = 1;
            if (uart_rxd_out !== expb) ok = 0;
            if (j == e.per / 2 && k >= 1 && k <= 8) got[k-1] = uart_rxd_out;
          end
          if (abort) break;
          check($sformatf("bit%0d_of_%02h", k, e.b), 32'(ok), 32'd1);
        end
        if (!abort) check("rx_byte", 32'(got), 32'(e.b));
        rx_busy = 0;
      end
      prev = uart_rxd_out;
    end
  end

  initial begin : main
    logic [31:0] d;
    int c0;
    bit flag;

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_line", 32'(uart_rxd_out), 32'd1);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    rd(A_ST, d);  check("rst_status", d, 32'h02);
    rd(A_DIV, d); check("rst_divisor", d, 32'd867);
    rd(A_TX, d);  check("txdata_reads_0", d, 32'd0);
    rd(A_RSV, d); check("reserved_reads_0", d, 32'd0);
    address = A_DIV; en = 0; #1 check("unselected_reads_0", data_out, 32'd0);
    flag = 1;
    repeat (20) begin @(negedge clk); if (uart_rxd_out !== 1'b1) flag = 0; end
    check("idle_line_high", 32'(flag), 32'd1);

    // single frame, 4 clk/bit
    st(A_DIV, 32'hFFFF_0003, 0);
    rd(A_DIV, d); check("div_sw", d, 32'd3);
    fstart.delete();
    tx(8'h55, 4, 1);
    c0 = cyc;
    repeat (5) @(negedge clk);
    rd(A_ST, d); check("busy_mid_frame", 32'(d[2]), 32'd1);
    drain(200);
    check("frames_single", 32'(fstart.size()), 32'd1);
    if (fstart.size() > 0) check("start_latency", 32'(fstart[0] - c0), 32'd2);
    check("tx_idle_after", 32'(tx_idle), 32'd1);

    // back-to-back frames
    fstart.delete();
    tx(8'hA5, 4, 0); tx(8'h3C, 4, 0); tx(8'hFF, 4, 0);
    flag = 1;
    repeat (100) begin rd(A_ST, d); if (d[2] !== 1'b1) flag = 0; @(negedge clk); end
    check("busy_throughout", 32'(flag), 32'd1);
    drain(300);
    check("frames_b2b", 32'(fstart.size()), 32'd3);
    if (fstart.size() == 3) begin
      check("gap_1_2", 32'(fstart[1] - fstart[0]), 32'd40);
      check("gap_2_3", 32'(fstart[2] - fstart[1]), 32'd40);
    end

    // fill, overflow, clear
    st(A_DIV, 32'd1000, 0);
    rx_en = 0;
    for (int i = 0; i < 9; i++) st(A_TX, 32'(i), 0);
    rd(A_ST, d); check("status_full_no_ovf", d, 32'h85);
    st(A_TX, 32'h77, 0);
    rd(A_ST, d); check("status_overflow", d, 32'h8D);
    st(A_ST, 32'h0, 0);
    rd(A_ST, d); check("status_ovf_cleared", d, 32'h85);
    rst = 1; repeat (2) @(negedge clk); rst = 0;
    @(negedge clk);
    rd(A_ST, d); check("status_after_rst1", d, 32'h02);
    rx_en = 1;

    // divisor change mid-frame applies to the next frame
    st(A_DIV, 32'd3, 0);
    fstart.delete();
    tx(8'h0F, 4, 1); tx(8'h96, 8, 1);
    repeat (10) @(negedge clk);
    st(A_DIV, 32'd7, 0);
    rd(A_DIV, d); check("div_mid_frame", d, 32'd7);
    drain(300);
    check("frames_divchg", 32'(fstart.size()), 32'd2);
    if (fstart.size() == 2) check("gap_divchg", 32'(fstart[1] - fstart[0]), 32'd40);

    // reset during data bit 4
    st(A_DIV, 32'd3, 0);
    rx_en = 0;
    st(A_TX, 32'h00, 0);
    c0 = cyc;
    st(A_TX, 32'h00, 0);
    while (cyc < c0 + 23) @(negedge clk);
    check("line_low_bit4", 32'(uart_rxd_out), 32'd0);
    rst = 1;
    @(negedge clk);
    check("line_high_after_rst", 32'(uart_rxd_out), 32'd1);
    @(negedge clk); rst = 0;
    @(negedge clk);
    rd(A_ST, d);  check("status_after_rst2", d, 32'h02);
    rd(A_DIV, d); check("div_after_rst", d, 32'd867);
    check("tx_idle_after_rst", 32'(tx_idle), 32'd1);
    flag = 1;
    repeat (60) begin @(negedge clk); if (uart_rxd_out !== 1'b1) flag = 0; end
    check("fifo_discarded", 32'(flag), 32'd1);
    rx_en = 1;

    // byte write to DIVISOR, then 1 clk/bit frames
    st(A_DIV, 32'h1234_56AB, 1);
    rd(A_DIV, d); check("div_sb", d, 32'h3AB);
    st(A_DIV, 32'd0, 0);
    fstart.delete();
    tx(8'h5A, 1, 0); tx(8'hC3, 1, 0);
    drain(100);
    check("frames_div0", 32'(fstart.size()), 32'd2);
    if (fstart.size() == 2) check("gap_div0", 32'(fstart[1] - fstart[0]), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
